// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus between a program
// source and the imem_loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master is the byte source that also watches memory writes; slave is the loader
    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction memory as 32-bit words,
// holding the processor in reset until the last word has been written.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR_W:0] load_len,
    imem_loader_if.slave    bus,
    output logic            cpu_rst,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned     DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W:0]   len_q,      len_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shift_q,    shift_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              err_q,      err_d;
    logic [ADDR_W:0]   word_next;
    logic [31:0]       word_full;

    assign word_next = word_cnt_q + 1'b1;
    assign word_full = {shift_q[23:0], bus.byte_data};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A rejected start leaves the state untouched, so DONE stays DONE
                if (start) begin
                    if (load_len == '0) begin
                        state_d = ST_DONE;
                    end else if (load_len > DEPTH) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = load_len;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.byte_valid) begin
                    shift_d    = word_full;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        addr_d  = word_cnt_q[ADDR_W-1:0];
                        wdata_d = word_full;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_next;
                byte_cnt_d = '0;
                state_d    = (word_next == len_q) ? ST_DONE : ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    // Every output comes from the state register or a flop; no input reaches an output
    assign bus.byte_ready = (state_q == ST_LOAD);
    assign bus.imem_we    = (state_q == ST_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst        = (state_q != ST_DONE);
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a queue of expected
// (address, word) writes is built from the byte stream and checked every cycle.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic [ADDR_W:0] load_len;
    logic            cpu_rst;
    logic            busy;
    logic            done;
    logic            err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_len (load_len),
        .bus      (bus),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int          total;
    int          bad;
    wr_t         exp_q[$];
    wr_t         mon_exp;
    logic        mon_en;
    logic        prev_we;
    int          writes;
    int          err_seen;
    int          exp_err;
    logic [7:0]  last_addr;
    logic [7:0]  stim_bytes [0:1023];
    int          n_bytes;
    time         t_start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Compare process: cycle invariants plus in-order matching of every memory write
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("cpu_rst_is_not_done", 32'(cpu_rst), 32'(!done));
            checkOutput("busy_is_load_or_write", 32'(busy), 32'(bus.byte_ready | bus.imem_we));
            checkOutput("done_excludes_busy", 32'(done & busy), 32'd0);
            if (bus.imem_we) begin
                checkOutput("we_one_cycle", 32'(prev_we), 32'd0);
                checkOutput("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("write_addr", 32'(bus.imem_addr), 32'(mon_exp.addr));
                    checkOutput("write_data", bus.imem_wdata, mon_exp.data);
                end
                writes++;
                last_addr = bus.imem_addr;
            end
            if (err) err_seen++;
            prev_we = bus.imem_we;
        end
    end

    task automatic clear_stim();
        n_bytes = 0;
    endtask

    task automatic add_literal_word(input int a, input logic [31:0] w);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = w;
        exp_q.push_back(e);
        stim_bytes[n_bytes]     = w[31:24];
        stim_bytes[n_bytes + 1] = w[23:16];
        stim_bytes[n_bytes + 2] = w[15:8];
        stim_bytes[n_bytes + 3] = w[7:0];
        n_bytes += 4;
    endtask

    task automatic add_random_word(input int a);
        int unsigned b0, b1, b2, b3;
        wr_t e;
        b0 = $urandom_range(255, 0);
        b1 = $urandom_range(255, 0);
        b2 = $urandom_range(255, 0);
        b3 = $urandom_range(255, 0);
        e.addr = ADDR_W'(a);
        e.data = b0 * 32'd16777216 + b1 * 32'd65536 + b2 * 32'd256 + b3;
        exp_q.push_back(e);
        stim_bytes[n_bytes]     = 8'(b0);
        stim_bytes[n_bytes + 1] = 8'(b1);
        stim_bytes[n_bytes + 2] = 8'(b2);
        stim_bytes[n_bytes + 3] = 8'(b3);
        n_bytes += 4;
    endtask

    // Pulses start for one sampling edge; returns at the falling edge after it
    task automatic applyStimulus(input logic [ADDR_W:0] len);
        start    = 1'b1;
        load_len = len;
        @(posedge clk);
        t_start = $time;
        @(negedge clk);
        start    = 1'b0;
        load_len = (ADDR_W + 1)'($urandom);
    endtask

    // Offers n bytes with random gaps; a byte advances only once it is actually taken
    task automatic stream_bytes(input int n, input int gmin, input int gmax, input bit noise);
        int g;
        int waited;
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(gmax, gmin);
            for (int k = 0; k < g; k++) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
                if (noise) begin
                    start    = 1'($urandom);
                    load_len = (ADDR_W + 1)'($urandom);
                end
                checkOutput("busy_while_loading", 32'(busy), 32'd1);
                @(negedge clk);
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = stim_bytes[i];
            waited = 0;
            while (!bus.byte_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!bus.byte_ready) begin
                checkOutput("byte_accept_timeout", 32'(bus.byte_ready), 32'd1);
                bus.byte_valid = 1'b0;
                start = 1'b0;
                return;
            end
            if (noise) begin
                start    = 1'($urandom);
                load_len = (ADDR_W + 1)'($urandom);
            end
            checkOutput("busy_while_loading", 32'(busy), 32'd1);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        start = 1'b0;
    endtask

    // Returns the number of rising edges from the start-sampling edge to done
    task automatic wait_done(output int edges);
        int n;
        n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_reached", 32'(done), 32'd1);
        edges = done ? int'(($time - 5 - t_start) / 10) : -1;
    endtask

    initial begin
        int   edges;
        int   wr0;
        int   len;
        logic was_done;

        total = 0; bad = 0; writes = 0; err_seen = 0; exp_err = 0;
        mon_en = 1'b0; prev_we = 1'b0; last_addr = '0; n_bytes = 0;
        rst = 1'b1; start = 1'b0; load_len = '0;
        bus.byte_valid = 1'b0; bus.byte_data = '0;

        // Reset values after two cycles of rst
        repeat (2) @(negedge clk);
        checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("rst_imem_wdata", bus.imem_wdata, 32'd0);
        checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_no_ready", 32'(bus.byte_ready), 32'd0);
        end
        bus.byte_valid = 1'b0;

        $display("[TB] length boundaries");
        applyStimulus((ADDR_W + 1)'(DEPTH + 1));
        exp_err++;
        checkOutput("oversize_err", 32'(err), 32'd1);
        checkOutput("oversize_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("oversize_idle", 32'(busy | done), 32'd0);
        @(negedge clk);
        checkOutput("oversize_err_one_cycle", 32'(err), 32'd0);
        applyStimulus('0);
        checkOutput("len0_done", 32'(done), 32'd1);
        checkOutput("len0_cpu_released", 32'(cpu_rst), 32'd0);
        checkOutput("len0_no_writes", 32'(writes), 32'd0);

        $display("[TB] two-word load, no gaps");
        clear_stim();
        add_literal_word(0, 32'h20080005);
        add_literal_word(1, 32'h8C090004);
        wr0 = writes;
        applyStimulus(9'd2);
        checkOutput("reload_cpu_rst_high", 32'(cpu_rst), 32'd1);
        stream_bytes(8, 0, 0, 1'b0);
        wait_done(edges);
        checkOutput("two_word_latency", 32'(edges), 32'd10);
        checkOutput("two_word_count", 32'(writes - wr0), 32'd2);
        checkOutput("two_word_all_written", 32'(exp_q.size()), 32'd0);

        $display("[TB] two-word load with 3-cycle gaps");
        clear_stim();
        add_literal_word(0, 32'h20080005);
        add_literal_word(1, 32'h8C090004);
        wr0 = writes;
        applyStimulus(9'd2);
        stream_bytes(8, 3, 3, 1'b0);
        wait_done(edges);
        checkOutput("gap_count", 32'(writes - wr0), 32'd2);
        checkOutput("gap_all_written", 32'(exp_q.size()), 32'd0);

        $display("[TB] full-depth load");
        clear_stim();
        for (int w = 0; w < DEPTH; w++) add_random_word(w);
        wr0 = writes;
        applyStimulus((ADDR_W + 1)'(DEPTH));
        stream_bytes(4 * DEPTH, 0, 0, 1'b1);
        wait_done(edges);
        checkOutput("full_latency", 32'(edges), 32'(5 * DEPTH));
        checkOutput("full_count", 32'(writes - wr0), 32'(DEPTH));
        checkOutput("full_last_addr", 32'(last_addr), 32'(DEPTH - 1));
        checkOutput("full_all_written", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset in the middle of word 1");
        clear_stim();
        add_random_word(0);
        add_random_word(1);
        wr0 = writes;
        applyStimulus(9'd2);
        stream_bytes(6, 0, 2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("midrst_idle", 32'(busy | done), 32'd0);
        checkOutput("midrst_word0_kept", 32'(writes - wr0), 32'd1);
        exp_q.delete();
        bus.byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.byte_valid = 1'b0;
        checkOutput("midrst_no_more_writes", 32'(writes - wr0), 32'd1);
        clear_stim();
        add_random_word(0);
        applyStimulus(9'd1);
        stream_bytes(4, 0, 2, 1'b0);
        wait_done(edges);
        checkOutput("fresh_all_written", 32'(exp_q.size()), 32'd0);

        $display("[TB] reload from DONE");
        clear_stim();
        add_random_word(0);
        wr0 = writes;
        applyStimulus(9'd1);
        checkOutput("reload_cpu_rst_rises", 32'(cpu_rst), 32'd1);
        stream_bytes(4, 0, 0, 1'b0);
        wait_done(edges);
        checkOutput("reload_latency", 32'(edges), 32'd5);
        checkOutput("reload_count", 32'(writes - wr0), 32'd1);

        $display("[TB] randomized loads");
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(6, 1);
            if ($urandom_range(3, 0) == 0) begin
                was_done = done;
                applyStimulus((ADDR_W + 1)'($urandom_range(511, DEPTH + 1)));
                exp_err++;
                checkOutput("rand_err_pulse", 32'(err), 32'd1);
                checkOutput("rand_reject_keeps_done", 32'(done), 32'(was_done));
            end
            clear_stim();
            for (int w = 0; w < len; w++) add_random_word(w);
            wr0 = writes;
            applyStimulus((ADDR_W + 1)'(len));
            checkOutput("rand_cpu_rst_held", 32'(cpu_rst), 32'd1);
            stream_bytes(4 * len, 0, 3, 1'b1);
            wait_done(edges);
            checkOutput("rand_count", 32'(writes - wr0), 32'(len));
            checkOutput("rand_all_written", 32'(exp_q.size()), 32'd0);
        end

        repeat (2) @(negedge clk);
        checkOutput("err_pulse_count", 32'(err_seen), 32'(exp_err));
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
